// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point complex multiplier.
//   FXP_WIDTH / FXP_FRAC_BITS : default operand width and fractional bits (Q8.8)
//   FXP_ONE / FXP_MAX / FXP_MIN : Q-format constants for the default width
//   state_t : controller states (idle, multiplying, result held)
//   phase_t : which partial product the shared multiplier forms this cycle
package fxp_pkg;

  localparam int FXP_WIDTH     = 16;
  localparam int FXP_FRAC_BITS = 8;

  localparam logic [FXP_WIDTH-1:0] FXP_ONE = 16'h0100;
  localparam logic [FXP_WIDTH-1:0] FXP_MAX = 16'h7FFF;
  localparam logic [FXP_WIDTH-1:0] FXP_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Phase order: re = ar*br - ai*bi, then im = ar*bi + ai*br.
  typedef enum logic [1:0] {
    PH_RR = 2'd0,
    PH_II = 2'd1,
    PH_RI = 2'd2,
    PH_IR = 2'd3
  } phase_t;

endpackage

// File: rtl/fxp_mul_scale.sv
// Combinational signed fixed-point multiply with rescale.
//   x, y : WIDTH-bit signed two's complement operands
//   prod : (x*y) >>> FRAC_BITS, floored, reduced to WIDTH bits
// Build option CMUL_SATURATE_EN: clamp the scaled product to the WIDTH-bit
// signed range instead of wrapping modulo 2^WIDTH.
module fxp_mul_scale #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] x_ext;
  logic [2*WIDTH-1:0] y_ext;
  logic [2*WIDTH-1:0] full;
  logic [2*WIDTH-1:0] shifted;

  // Sign-extending to 2*WIDTH first makes the low 2*WIDTH bits of an
  // unsigned multiply equal the exact signed product.
  assign x_ext   = {{WIDTH{x[WIDTH-1]}}, x};
  assign y_ext   = {{WIDTH{y[WIDTH-1]}}, y};
  assign full    = x_ext * y_ext;
  assign shifted = $signed(full) >>> FRAC_BITS;

`ifdef CMUL_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic in_range;

  // Representable iff every bit from the result sign upward is identical.
  assign in_range = (&shifted[2*WIDTH-1:WIDTH-1]) | ~(|shifted[2*WIDTH-1:WIDTH-1]);

  always_comb begin
    prod = shifted[WIDTH-1:0];
    if (!in_range) prod = shifted[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
  end
`else
  logic unused_hi;

  assign unused_hi = ^shifted[2*WIDTH-1:WIDTH];
  assign prod      = shifted[WIDTH-1:0];
`endif

endmodule

// File: rtl/fixed_point_cmul_seq.sv
// Sequential complex multiplier: p = (a_re + j*a_im) * (b_re + j*b_im).
// One shared fxp_mul_scale is time-multiplexed over four phases.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake; operands latched on acceptance
//   a_re, a_im, b_re, b_im : WIDTH-bit signed Q operands
//   out_valid / out_ready  : result handshake; result held until accepted
//   p_re, p_im          : WIDTH-bit signed Q product, updated on DONE entry
// Build option CMUL_SATURATE_EN: every scaled product and accumulate step
// saturates instead of wrapping; timing and handshake are unchanged.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for operands, p_* holds the previous result
// ST_MUL  | four phases through the shared multiplier, inputs ignored
// ST_DONE | out_valid=1, p_* stable until out_ready
module fixed_point_cmul_seq
  import fxp_pkg::*;
#(
  parameter int WIDTH     = FXP_WIDTH,
  parameter int FRAC_BITS = FXP_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_re,
  output logic [WIDTH-1:0] p_im
);

  state_t state, state_next;
  phase_t phase;

  logic [WIDTH-1:0] ar, ai, br, bi;
  logic [WIDTH-1:0] acc_re, acc_im;
  logic [WIDTH-1:0] mul_x, mul_y, prod;
  logic [WIDTH-1:0] acc_in, acc_next;
  logic             acc_sub;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid)          state_next = ST_MUL;
      ST_MUL:  if (phase == PH_IR)    state_next = ST_DONE;
      ST_DONE: if (out_ready)         state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Operand mux for the shared multiplier.
  always_comb begin
    mul_x = ((phase == PH_RR) || (phase == PH_RI)) ? ar : ai;
    mul_y = ((phase == PH_RR) || (phase == PH_IR)) ? br : bi;
  end

  fxp_mul_scale #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .x    (mul_x),
    .y    (mul_y),
    .prod (prod)
  );

  // Second partial product of each component folds into its accumulator:
  // subtract for the real part, add for the imaginary part.
  assign acc_sub = (phase == PH_II);
  assign acc_in  = acc_sub ? acc_re : acc_im;

`ifdef CMUL_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] sum_ext;

  always_comb begin
    if (acc_sub) sum_ext = {acc_in[WIDTH-1], acc_in} - {prod[WIDTH-1], prod};
    else         sum_ext = {acc_in[WIDTH-1], acc_in} + {prod[WIDTH-1], prod};
    acc_next = sum_ext[WIDTH-1:0];
    // Top two bits disagree only when the true sum left the WIDTH-bit range.
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) acc_next = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
  end
`else
  assign acc_next = acc_sub ? (acc_in - prod) : (acc_in + prod);
`endif

  // Datapath: operand capture, phase counter, accumulators, result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar     <= '0;
      ai     <= '0;
      br     <= '0;
      bi     <= '0;
      acc_re <= '0;
      acc_im <= '0;
      p_re   <= '0;
      p_im   <= '0;
      phase  <= PH_RR;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ar    <= a_re;
            ai    <= a_im;
            br    <= b_re;
            bi    <= b_im;
            phase <= PH_RR;
          end
        end
        ST_MUL: begin
          phase <= phase_t'(phase + 2'd1);
          unique case (phase)
            PH_RR: acc_re <= prod;
            PH_II: acc_re <= acc_next;
            PH_RI: acc_im <= prod;
            PH_IR: begin
              // acc_re is final after PH_II; the imaginary part completes
              // this cycle, so it is taken straight from the adder.
              acc_im <= acc_next;
              p_re   <= acc_re;
              p_im   <= acc_next;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_cmul_seq.sv
module tb_fixed_point_cmul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p_re, p_im;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_re = '0, exp_im = '0;
  logic [15:0] last_re = '0, last_im = '0;
  bit          mon_en = 1'b0;

  fixed_point_cmul_seq #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_re      (p_re),
    .p_im      (p_im)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint fit(input longint v);
`ifdef CMUL_SATURATE_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint w;
    w = v & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  function automatic longint sgn(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  // (x*y) / 2^8 rounded toward -inf, then reduced to 16 bits
  function automatic longint scale(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = sgn(x) * sgn(y);
    if (p >= 0) p = p / 256;
    else        p = -((-p + 255) / 256);
    return fit(p);
  endfunction

  function automatic logic [31:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                        input logic [15:0] br, input logic [15:0] bi);
    longint re, im;
    logic [15:0] r16, i16;
    re  = fit(scale(ar, br) - scale(ai, bi));
    im  = fit(scale(ar, bi) + scale(ai, br));
    r16 = re[15:0];
    i16 = im[15:0];
    return {r16, i16};
  endfunction

  // ---------------- output compare process ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid) begin
        check("p_re_valid", {16'h0, p_re}, {16'h0, exp_re});
        check("p_im_valid", {16'h0, p_im}, {16'h0, exp_im});
        last_re = exp_re;
        last_im = exp_im;
      end else begin
        check("p_re_hold", {16'h0, p_re}, {16'h0, last_re});
        check("p_im_hold", {16'h0, p_im}, {16'h0, last_im});
      end
    end
  end

  function automatic logic [15:0] rand_operand();
    logic [15:0] corners [6];
    corners = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFF00, 16'h0000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  // One full transaction; inputs change #1 after rising edges.
  task automatic do_op(input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi,
                       input int bp, input bit junk,
                       output logic [15:0] got_re, output logic [15:0] got_im);
    int cnt;
    logic [31:0] e;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("in_ready_before_op", {31'h0, in_ready}, 32'h1);
    e = model(ar, ai, br, bi);
    exp_re = e[31:16];
    exp_im = e[15:0];
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;             // accepting edge has passed
    in_valid = junk;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      check("in_ready_busy", {31'h0, in_ready}, 32'h0);
      if (junk) begin
        a_re = 16'($urandom); a_im = 16'($urandom);
        b_re = 16'($urandom); b_im = 16'($urandom);
      end
      @(posedge clk); #1;
      cnt++;
    end
    check("latency_edges", cnt, 4);
    got_re = p_re;
    got_im = p_im;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_p_re_stable", {16'h0, p_re}, {16'h0, got_re});
      check("bp_p_im_stable", {16'h0, p_im}, {16'h0, got_im});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", {31'h0, out_valid}, 32'h0);
    check("in_ready_return", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b0;
  endtask

  logic [15:0] gr, gi;
  logic [31:0] m;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;

    // pin the model against hand-computed values
    m = model(16'h0100, 16'h0100, 16'h0100, 16'hFF00);
    check("model_case1", m, 32'h0200_0000);
    m = model(16'h0080, 16'h0000, 16'h0000, 16'h0100);
    check("model_case2", m, 32'h0000_0080);
    m = model(16'hFFFF, 16'h0000, 16'h0080, 16'h0000);
    check("model_floor", m, 32'hFFFF_0000);
    m = model(16'h7F00, 16'h0000, 16'h0200, 16'h0000);
`ifdef CMUL_SATURATE_EN
    check("model_ovf", m, 32'h7FFF_0000);
`else
    check("model_ovf", m, 32'hFE00_0000);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_p", {p_re, p_im}, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // directed cases with literal results
    do_op(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 0, 1'b0, gr, gi);
    check("dir_1p1j_x_1m1j", {gr, gi}, 32'h0200_0000);
    do_op(16'h0080, 16'h0000, 16'h0000, 16'h0100, 1, 1'b0, gr, gi);
    check("dir_half_x_j", {gr, gi}, 32'h0000_0080);
    do_op(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 0, 1'b0, gr, gi);
    check("dir_floor", {gr, gi}, 32'hFFFF_0000);
    do_op(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 0, 1'b0, gr, gi);
`ifdef CMUL_SATURATE_EN
    check("dir_overflow", {gr, gi}, 32'h7FFF_0000);
`else
    check("dir_overflow", {gr, gi}, 32'hFE00_0000);
`endif
    // backpressure for 10 cycles with junk on the inputs
    do_op(16'h0180, 16'hFE40, 16'h0321, 16'h00A5, 10, 1'b1, gr, gi);
    m = model(16'h0180, 16'hFE40, 16'h0321, 16'h00A5);
    check("dir_bp_junk", {gr, gi}, m);

    // async reset during phase 2
    exp_re = 16'h1234; exp_im = 16'h5678;
    a_re = 16'h0300; a_im = 16'h0200; b_re = 16'h0100; b_im = 16'h0400;
    in_valid = 1'b1;
    @(posedge clk); #1;             // accepted, phase 0
    in_valid = 1'b0;
    @(posedge clk); #1;             // phase 1
    @(posedge clk); #1;             // phase 2
    rst = 1'b1;
    last_re = '0; last_im = '0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check("arst_in_ready", {31'h0, in_ready}, 32'h1);
    check("arst_p", {p_re, p_im}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 0, 1'b0, gr, gi);
    check("after_rst_op", {gr, gi}, 32'h0200_0000);

    // randomized transactions
    for (int k = 0; k < 60; k++) begin
      logic [15:0] r0, r1, r2, r3;
      r0 = rand_operand(); r1 = rand_operand();
      r2 = rand_operand(); r3 = rand_operand();
      do_op(r0, r1, r2, r3, $urandom_range(0, 3), 1'($urandom_range(0, 1)), gr, gi);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
